// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter with optional line lock in front of one uart_tx
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LINE_LOCK    = 1,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [1:0]           owner,
    output logic                 locked,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_send,
    input  logic                 uart_tx_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Terminal idle count: the lock drops on the edge where the counter sits here.
    localparam logic [23:0] CNT_TERM = 24'(LOCK_TIMEOUT - 1);
    // Pointer starts at the last requester so req0 wins the first search.
    localparam logic [1:0]  RR_INIT  = 2'(NUM_REQ - 1);

    state_t               state, state_n;
    logic [1:0]           rr_ptr, rr_ptr_n;
    logic [1:0]           owner_n;
    logic [23:0]          idle_cnt, idle_cnt_n;
    logic                 locked_n;
    logic                 send_n;
    logic [7:0]           data_n;
    logic [NUM_REQ-1:0]   ack_n;

    logic [3:0]           req_ext;
    logic [7:0]           byte_arr [4];
    logic                 grant_vld;
    logic [1:0]           grant_idx;
    logic [1:0]           cand;
    logic [7:0]           grant_byte;

    // Widen the request vector and byte lanes to four slots so 2-bit indices are always in range.
    always_comb begin
        req_ext = '0;
        for (int i = 0; i < 4; i++) begin
            byte_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ext[i]  = req[i];
            byte_arr[i] = req_data[8*i +: 8];
        end
    end

    // Pick the next requester: only the owner while locked, otherwise round-robin after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        if (locked) begin
            grant_vld = req_ext[owner];
            grant_idx = owner;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_vld && req_ext[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant_byte = byte_arr[grant_idx];
    end

    // Next-state logic: send handshake sequencing, grant capture, lock and idle timeout.
    always_comb begin
        state_n    = state;
        send_n     = uart_tx_send;
        data_n     = uart_tx_data;
        ack_n      = '0;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        locked_n   = locked;
        idle_cnt_n = idle_cnt;

        // A grant can only happen while the owner is requesting, so the timeout never collides with it.
        if (!locked || req_ext[owner]) begin
            idle_cnt_n = '0;
        end else if (idle_cnt >= CNT_TERM) begin
            locked_n   = 1'b0;
            idle_cnt_n = '0;
        end else begin
            idle_cnt_n = idle_cnt + 24'd1;
        end

        case (state)
            S_IDLE: begin
                if (uart_tx_ready && grant_vld) begin
                    data_n     = grant_byte;
                    send_n     = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_n[i] = (2'(i) == grant_idx);
                    end
                    owner_n    = grant_idx;
                    rr_ptr_n   = grant_idx;
                    idle_cnt_n = '0;
                    state_n    = S_SEND;
                    if (LINE_LOCK != 0) begin
                        locked_n = (grant_byte != 8'h0A);
                    end else begin
                        locked_n = 1'b0;
                    end
                end
            end
            S_SEND: begin
                // uart_tx acknowledges the level-held send by dropping ready.
                if (!uart_tx_ready) begin
                    send_n  = 1'b0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                // Ready stays low while the uart_tx buffer is full; this is the flow control.
                if (uart_tx_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                send_n  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            uart_tx_send <= 1'b0;
            uart_tx_data <= '0;
            ack          <= '0;
            owner        <= '0;
            rr_ptr       <= RR_INIT;
            locked       <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            state        <= state_n;
            uart_tx_send <= send_n;
            uart_tx_data <= data_n;
            ack          <= ack_n;
            owner        <= owner_n;
            rr_ptr       <= rr_ptr_n;
            locked       <= locked_n;
            idle_cnt     <= idle_cnt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // Locking instance, short timeout
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  ack;
    logic [1:0]  owner;
    logic        locked;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        rdy;

    // Per-byte instance
    logic [1:0]  req2;
    logic [15:0] req_data2;
    logic [1:0]  ack2;
    logic [1:0]  owner2;
    logic        locked2;
    logic [7:0]  tx_data2;
    logic        tx_send2;
    logic        rdy2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] e_ack;
        logic       e_send;
        logic [7:0] e_data;
        logic [1:0] e_owner;
        logic       e_locked;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    uart_tx_arbiter #(.NUM_REQ(2), .LINE_LOCK(1), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .owner(owner), .locked(locked), .uart_tx_data(tx_data),
        .uart_tx_send(tx_send), .uart_tx_ready(rdy)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .LINE_LOCK(0), .LOCK_TIMEOUT(16)) dut_rr (
        .clk(clk), .reset(reset), .req(req2), .req_data(req_data2), .ack(ack2),
        .owner(owner2), .locked(locked2), .uart_tx_data(tx_data2),
        .uart_tx_send(tx_send2), .uart_tx_ready(rdy2)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;

        // req, d0, d1, rdy | ack, send, data, owner, locked
        tbl[0]  = '{2'b01, 8'h41, 8'h00, 1'b1, 2'b01, 1'b1, 8'h41, 2'd0, 1'b1};
        tbl[1]  = '{2'b00, 8'h41, 8'h00, 1'b1, 2'b00, 1'b1, 8'h41, 2'd0, 1'b1};
        tbl[2]  = '{2'b00, 8'h41, 8'h00, 1'b0, 2'b00, 1'b0, 8'h41, 2'd0, 1'b1};
        tbl[3]  = '{2'b00, 8'h41, 8'h00, 1'b1, 2'b00, 1'b0, 8'h41, 2'd0, 1'b1};
        tbl[4]  = '{2'b00, 8'h41, 8'h00, 1'b1, 2'b00, 1'b0, 8'h41, 2'd0, 1'b1};
        tbl[5]  = '{2'b11, 8'h41, 8'h55, 1'b1, 2'b01, 1'b1, 8'h41, 2'd0, 1'b1};
        tbl[6]  = '{2'b10, 8'h41, 8'h55, 1'b1, 2'b00, 1'b1, 8'h41, 2'd0, 1'b1};
        tbl[7]  = '{2'b10, 8'h41, 8'h55, 1'b0, 2'b00, 1'b0, 8'h41, 2'd0, 1'b1};
        tbl[8]  = '{2'b11, 8'h42, 8'h55, 1'b1, 2'b00, 1'b0, 8'h41, 2'd0, 1'b1};
        tbl[9]  = '{2'b11, 8'h42, 8'h55, 1'b1, 2'b01, 1'b1, 8'h42, 2'd0, 1'b1};
        tbl[10] = '{2'b10, 8'h42, 8'h55, 1'b1, 2'b00, 1'b1, 8'h42, 2'd0, 1'b1};
        tbl[11] = '{2'b10, 8'h42, 8'h55, 1'b0, 2'b00, 1'b0, 8'h42, 2'd0, 1'b1};
        tbl[12] = '{2'b11, 8'h0A, 8'h55, 1'b1, 2'b00, 1'b0, 8'h42, 2'd0, 1'b1};
        tbl[13] = '{2'b11, 8'h0A, 8'h55, 1'b1, 2'b01, 1'b1, 8'h0A, 2'd0, 1'b0};
        tbl[14] = '{2'b10, 8'h0A, 8'h55, 1'b1, 2'b00, 1'b1, 8'h0A, 2'd0, 1'b0};
        tbl[15] = '{2'b10, 8'h0A, 8'h55, 1'b0, 2'b00, 1'b0, 8'h0A, 2'd0, 1'b0};
        tbl[16] = '{2'b10, 8'h0A, 8'h55, 1'b1, 2'b00, 1'b0, 8'h0A, 2'd0, 1'b0};
        tbl[17] = '{2'b10, 8'h0A, 8'h55, 1'b1, 2'b10, 1'b1, 8'h55, 2'd1, 1'b1};
        tbl[18] = '{2'b00, 8'h0A, 8'hEE, 1'b1, 2'b00, 1'b1, 8'h55, 2'd1, 1'b1};
        tbl[19] = '{2'b00, 8'h0A, 8'hEE, 1'b0, 2'b00, 1'b0, 8'h55, 2'd1, 1'b1};
        tbl[20] = '{2'b00, 8'h0A, 8'hEE, 1'b1, 2'b00, 1'b0, 8'h55, 2'd1, 1'b1};

        reset = 1'b1;
        req = '0; req_data = '0; rdy = 1'b1;
        req2 = '0; req_data2 = '0; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({ack, tx_send, tx_data, owner, locked}), 32'(0));
        check("rst_outputs_rr", 32'({ack2, tx_send2, tx_data2, owner2, locked2}), 32'(0));
        reset = 1'b0;

        // Single byte, then "AB\n" with req1 held off until LF, then req1 granted
        for (int i = 0; i < NVEC; i++) begin
            req      = tbl[i].req;
            req_data = {tbl[i].d1, tbl[i].d0};
            rdy      = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d", i), 32'({ack, tx_send, tx_data, owner, locked}),
                  32'({tbl[i].e_ack, tbl[i].e_send, tbl[i].e_data, tbl[i].e_owner, tbl[i].e_locked}));
        end
        req = '0;

        // Round-robin, per-byte arbitration: grants alternate 0,1,0,1
        req2 = 2'b11; req_data2 = {8'h31, 8'h30}; rdy2 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("rr_grant%0d", n), 32'({ack2, tx_send2, tx_data2, owner2, locked2}),
                  32'({(n % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (n % 2 == 0) ? 8'h30 : 8'h31,
                       2'(n % 2), 1'b0}));
            rdy2 = 1'b0;
            tick();
            check($sformatf("rr_gap%0d", n), 32'({ack2, tx_send2}), 32'(0));
            rdy2 = 1'b1;
            tick();
            check($sformatf("rr_idle%0d", n), 32'({ack2, tx_send2}), 32'(0));
        end
        req2 = '0;

        // Lock timeout: req0 sends one byte and goes quiet while req1 waits
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 2'b11; req_data = {8'h31, 8'h41}; rdy = 1'b1;
        tick();
        check("to_grant0", 32'({ack, locked, tx_data}), 32'({2'b01, 1'b1, 8'h41}));
        req = 2'b10; rdy = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) rdy = 1'b1;
            check($sformatf("to_hold%0d", k), 32'({ack, locked}), 32'({2'b00, 1'b1}));
        end
        tick();
        check("to_release", 32'({ack, locked}), 32'({2'b00, 1'b0}));
        tick();
        check("to_grant1", 32'({ack, owner, tx_data, tx_send}), 32'({2'b10, 2'd1, 8'h31, 1'b1}));

        // Backpressure: ready held low in the gap, nothing moves
        req = 2'b11; req_data = {8'h32, 8'h41}; rdy = 1'b0;
        tick();
        check("bp_enter_gap", 32'({ack, tx_send}), 32'(0));
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if ({ack, tx_send, tx_data, owner, locked} !== {2'b00, 1'b0, 8'h31, 2'd1, 1'b1}) bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'(0));
        rdy = 1'b1;
        tick();
        check("bp_ready_back", 32'({ack, tx_send}), 32'(0));
        tick();
        check("bp_next_grant", 32'({ack, owner, tx_data, tx_send}), 32'({2'b10, 2'd1, 8'h32, 1'b1}));

        // Reset while send is high takes effect without a clock edge
        req = '0;
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_send", 32'({ack, tx_send, tx_data, owner, locked}), 32'(0));
        reset = 1'b0;
        req = 2'b10; req_data = {8'h77, 8'h00}; rdy = 1'b1;
        tick();
        check("post_rst_grant", 32'({ack, owner, tx_data, tx_send}), 32'({2'b10, 2'd1, 8'h77, 1'b1}));
        req = '0; rdy = 1'b0;
        tick();
        rdy = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
